// File: rtl/presettable_updown_counter.sv
// Modulo-N up/down counter clocked on the falling edge, with preset, clamped
// parallel load, combinational terminal count and a registered boundary pulse.
module presettable_updown_counter #(
    parameter int     WIDTH      = 4,
    parameter longint MODULUS    = 10,
    parameter longint PRESET_VAL = 9,
    parameter bit     SATURATE   = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             PRESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] PRESET_Q = WIDTH'(PRESET_VAL);
    localparam logic [63:0]      MOD_U    = 64'(MODULUS);

    logic             at_limit_seen;
    logic             up_q;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             seen_next;
    logic             seen_eff;
    logic             at_boundary;
    logic [WIDTH-1:0] load_val;

    // A direction change re-arms the saturate pulse in the same edge it is seen.
    assign seen_eff    = at_limit_seen && (UP == up_q);
    assign at_boundary = UP ? (Q == MAX_Q) : (Q == '0);
    assign load_val    = (64'(D) >= MOD_U) ? MAX_Q : D;
    assign TC          = at_boundary;

    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        seen_next = seen_eff;
        if (PRESET) begin
            q_next    = PRESET_Q;
            seen_next = 1'b0;
        end else if (LOAD) begin
            q_next    = load_val;
            seen_next = 1'b0;
        end else if (EN) begin
            if (!at_boundary) begin
                // Only stepping away from the boundary, so no adder overflow.
                q_next    = UP ? (Q + 1'b1) : (Q - 1'b1);
                seen_next = 1'b0;
            end else if (!SATURATE) begin
                q_next    = UP ? '0 : MAX_Q;
                wrap_next = 1'b1;
                seen_next = 1'b0;
            end else begin
                wrap_next = !seen_eff;
                seen_next = 1'b1;
            end
        end
    end

    always_ff @(negedge CLK) begin
        up_q <= UP;
        if (!CLR_N) begin
            Q             <= '0;
            WRAP          <= 1'b0;
            at_limit_seen <= 1'b0;
        end else begin
            Q             <= q_next;
            WRAP          <= wrap_next;
            at_limit_seen <= seen_next;
        end
    end

endmodule

// File: tb/tb_presettable_updown_counter.sv
// Bench for presettable_updown_counter: three configurations (default wrap,
// saturate, full 3-bit range) driven side by side against a reference model.
module tb_presettable_updown_counter;

    logic       clk;
    logic       clr_n  [3];
    logic       preset [3];
    logic       load   [3];
    logic       en     [3];
    logic       up     [3];
    logic [3:0] d      [3];
    logic [3:0] q0, q1;
    logic [2:0] q2;
    logic       tc     [3];
    logic       wrap   [3];

    int checks   = 0;
    int failures = 0;

    localparam int M_OF  [3] = '{10, 10, 8};
    localparam int PV_OF [3] = '{9, 9, 5};
    localparam bit SAT_OF[3] = '{1'b0, 1'b1, 1'b0};
    localparam int DM_OF [3] = '{15, 15, 7};

    typedef struct {
        int q;
        bit wrap;
        bit seen;
        bit up_prev;
    } model_t;

    model_t ms[3];

    presettable_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESET_VAL(9), .SATURATE(1'b0)) u_dflt (
        .CLK(clk), .CLR_N(clr_n[0]), .PRESET(preset[0]), .LOAD(load[0]), .D(d[0]),
        .EN(en[0]), .UP(up[0]), .Q(q0), .TC(tc[0]), .WRAP(wrap[0]));

    presettable_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESET_VAL(9), .SATURATE(1'b1)) u_sat (
        .CLK(clk), .CLR_N(clr_n[1]), .PRESET(preset[1]), .LOAD(load[1]), .D(d[1]),
        .EN(en[1]), .UP(up[1]), .Q(q1), .TC(tc[1]), .WRAP(wrap[1]));

    presettable_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESET_VAL(5), .SATURATE(1'b0)) u_full (
        .CLK(clk), .CLR_N(clr_n[2]), .PRESET(preset[2]), .LOAD(load[2]), .D(d[2][2:0]),
        .EN(en[2]), .UP(up[2]), .Q(q2), .TC(tc[2]), .WRAP(wrap[2]));

    // Clock / reset block: falling edge is the active edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: counts in plain integers modulo m.
    function automatic model_t model_step(model_t s, int m, int pv, bit sat,
                                          bit c, bit p, bit l, int dv, bit e, bit u);
        model_t n = s;
        bit seen_e;
        bit bound;
        seen_e    = s.seen && (u == s.up_prev);
        n.up_prev = u;
        n.wrap    = 1'b0;
        n.seen    = seen_e;
        if (!c) begin
            n.q    = 0;
            n.seen = 1'b0;
        end else if (p) begin
            n.q    = pv;
            n.seen = 1'b0;
        end else if (l) begin
            n.q    = (dv < m) ? dv : m - 1;
            n.seen = 1'b0;
        end else if (e) begin
            bound = u ? (s.q == m - 1) : (s.q == 0);
            if (bound && sat) begin
                n.wrap = !seen_e;
                n.seen = 1'b1;
            end else begin
                n.q    = (s.q + (u ? 1 : m - 1)) % m;
                n.wrap = bound;
                n.seen = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_of(int i);
        if (i == 0) return 32'(q0);
        if (i == 1) return 32'(q1);
        return 32'(q2);
    endfunction

    // Driver tasks.
    task automatic drive(int i, bit c, bit p, bit l, bit e, bit u, int dv);
        clr_n[i]  = c;
        preset[i] = p;
        load[i]   = l;
        en[i]     = e;
        up[i]     = u;
        d[i]      = 4'(dv);
    endtask

    task automatic idle(int i);
        drive(i, 1'b1, 1'b0, 1'b0, 1'b0, up[i], 0);
    endtask

    // One active edge: update the scoreboard at the falling edge, compare on the rising edge.
    task automatic step();
        logic [31:0] exp_tc;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            ms[i] = model_step(ms[i], M_OF[i], PV_OF[i], SAT_OF[i], clr_n[i], preset[i],
                               load[i], int'(d[i]) & DM_OF[i], en[i], up[i]);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_tc = 32'((up[i] && ms[i].q == M_OF[i] - 1) || (!up[i] && ms[i].q == 0));
            check($sformatf("i%0d_q", i), q_of(i), 32'(ms[i].q));
            check($sformatf("i%0d_wrap", i), 32'(wrap[i]), 32'(ms[i].wrap));
            check($sformatf("i%0d_tc", i), 32'(tc[i]), exp_tc);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ms[i] = '{q: 0, wrap: 1'b0, seen: 1'b0, up_prev: 1'b1};
            drive(i, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3);
        end
        step();
        check("plan_reset_q", q_of(0), 0);
        check("plan_reset_wrap", 32'(wrap[0]), 0);
        check("plan_reset_tc", 32'(tc[0]), 0);
        for (int i = 0; i < 3; i++) idle(i);

        // Up count and wrap across 12 edges.
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        step();
        check("plan_release_q", q_of(0), 1);
        for (int k = 0; k < 11; k++) begin
            step();
            if (k == 8) check("plan_up_wrap_pulse", 32'(wrap[0]), 1);
        end
        check("plan_up_end_q", q_of(0), 2);

        // Down count through zero.
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        step();
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 4; k++) step();
        check("plan_down_end_q", q_of(0), 8);

        // Priority and clamp.
        drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        step();
        check("plan_preset_over_load", q_of(0), 9);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15);
        step();
        check("plan_load_clamp", q_of(0), 9);
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4);
        step();
        check("plan_load_over_en", q_of(0), 4);
        idle(0);

        // Saturate mode.
        drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8);
        step();
        drive(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) check("plan_sat_first_pulse", 32'(wrap[1]), 1);
            if (k == 3) check("plan_sat_no_repeat", 32'(wrap[1]), 0);
        end
        check("plan_sat_hold_q", q_of(1), 9);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();
        check("plan_sat_reverse_q", q_of(1), 8);
        idle(1);

        // Full range (modulus equals 2^WIDTH).
        drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        step();
        drive(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        step();
        check("plan_full_wrap_q", q_of(2), 0);
        check("plan_full_wrap_pulse", 32'(wrap[2]), 1);
        for (int k = 0; k < 5; k++) step();
        check("plan_full_mid_q", q_of(2), 5);
        drive(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        step();
        check("plan_full_midreset_q", q_of(2), 0);
        idle(2);

        // Randomized traffic on all three instances.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++)
                drive(i, $urandom_range(0, 19) != 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7) != 0 ? up[i] : !up[i],
                      int'($urandom_range(0, 15)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
